// File: rtl/adc_readout_ctrl.sv
// Request-driven conversion/read sequencer for an external 8-bit parallel ADC.
// Define ADC_AVG_EN to average four conversions per request.
module adc_readout_ctrl #(
  parameter int CONVST_CYC  = 2,
  parameter int RD_CYC      = 3,
  parameter int EOC_TIMEOUT = 64,
  parameter int RECOV_CYC   = 4
)(
  input  logic       clk_10MHz,
  input  logic       reset,
  input  logic       locked,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] result,
  input  logic       ADC_EOC,
  input  logic [7:0] Data,
  output logic       ADC_CONVST,
  output logic       ADC_RD,
  output logic       ADC_PD
);
  localparam int M01  = (CONVST_CYC > RD_CYC) ? CONVST_CYC : RD_CYC;
  localparam int M23  = (EOC_TIMEOUT > RECOV_CYC) ? EOC_TIMEOUT : RECOV_CYC;
  localparam int CMAX = (M01 > M23) ? M01 : M23;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT_EOC, READ, DONE, RECOV} state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          eoc_s1, eoc_s2;
  logic          nxt_convst, nxt_rd, nxt_done, nxt_timeout;
  logic [7:0]    nxt_result;
`ifdef ADC_AVG_EN
  logic [9:0]    acc, nxt_acc;
  logic [1:0]    idx, nxt_idx;
`else
  logic [7:0]    cap, nxt_cap;
`endif

  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_convst  = 1'b1;
    nxt_rd      = 1'b1;
    nxt_done    = 1'b0;
    nxt_timeout = 1'b0;
    nxt_result  = result;
`ifdef ADC_AVG_EN
    nxt_acc     = acc;
    nxt_idx     = idx;
`else
    nxt_cap     = cap;
`endif
    case (state)
      IDLE: begin
        // PD still high means lock was only just regained: wait one more cycle
        if (start && locked && !ADC_PD) begin
          nxt_state  = CONV;
          nxt_cnt    = CW'(CONVST_CYC);
          nxt_convst = 1'b0;
        end
      end
      CONV: begin
        if (cnt == CW'(1)) begin
          nxt_state = WAIT_EOC;
          nxt_cnt   = CW'(EOC_TIMEOUT);
        end else begin
          nxt_cnt    = cnt - CW'(1);
          nxt_convst = 1'b0;
        end
      end
      WAIT_EOC: begin
        if (!eoc_s2) begin
          nxt_state = READ;
          nxt_cnt   = CW'(RD_CYC);
          nxt_rd    = 1'b0;
        end else if (cnt == CW'(1)) begin
          nxt_timeout = 1'b1;
          nxt_state   = RECOV;
          nxt_cnt     = CW'(RECOV_CYC);
`ifdef ADC_AVG_EN
          nxt_acc     = '0;
          nxt_idx     = '0;
`endif
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      READ: begin
        if (cnt == CW'(1)) begin
`ifdef ADC_AVG_EN
          nxt_acc = acc + {2'b00, Data};
          if (idx == 2'd3) begin
            nxt_state = DONE;
            nxt_idx   = '0;
          end else begin
            nxt_state = RECOV;
            nxt_cnt   = CW'(RECOV_CYC);
            nxt_idx   = idx + 2'd1;
          end
`else
          nxt_cap   = Data;
          nxt_state = DONE;
`endif
        end else begin
          nxt_cnt = cnt - CW'(1);
          nxt_rd  = 1'b0;
        end
      end
      DONE: begin
        nxt_done  = 1'b1;
        nxt_state = RECOV;
        nxt_cnt   = CW'(RECOV_CYC);
`ifdef ADC_AVG_EN
        nxt_result = acc[9:2];
        nxt_acc    = '0;
`else
        nxt_result = cap;
`endif
      end
      RECOV: begin
        if (cnt == CW'(1)) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
`ifdef ADC_AVG_EN
          // mid-set: chain straight into the next conversion
          if (idx != 2'd0) begin
            nxt_state  = CONV;
            nxt_cnt    = CW'(CONVST_CYC);
            nxt_convst = 1'b0;
          end
`endif
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
    // lock loss aborts silently from any active state
    if (state != IDLE && !locked) begin
      nxt_state   = IDLE;
      nxt_cnt     = '0;
      nxt_convst  = 1'b1;
      nxt_rd      = 1'b1;
      nxt_done    = 1'b0;
      nxt_timeout = 1'b0;
      nxt_result  = result;
`ifdef ADC_AVG_EN
      nxt_acc     = '0;
      nxt_idx     = '0;
`endif
    end
  end

  always_ff @(posedge clk_10MHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      eoc_s1     <= 1'b1;
      eoc_s2     <= 1'b1;
      ADC_CONVST <= 1'b1;
      ADC_RD     <= 1'b1;
      ADC_PD     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      result     <= '0;
`ifdef ADC_AVG_EN
      acc        <= '0;
      idx        <= '0;
`else
      cap        <= '0;
`endif
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      eoc_s1     <= ADC_EOC;
      eoc_s2     <= eoc_s1;
      ADC_CONVST <= nxt_convst;
      ADC_RD     <= nxt_rd;
      ADC_PD     <= ~locked;
      busy       <= (nxt_state != IDLE);
      done       <= nxt_done;
      timeout    <= nxt_timeout;
      result     <= nxt_result;
`ifdef ADC_AVG_EN
      acc        <= nxt_acc;
      idx        <= nxt_idx;
`else
      cap        <= nxt_cap;
`endif
    end
  end
endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Directed bench for adc_readout_ctrl with a simple ADC model driving EOC/Data.
`timescale 1ns/1ps
module tb_adc_readout_ctrl;
  logic       clk = 1'b0;
  logic       reset, locked, start, ADC_EOC;
  logic [7:0] Data;
  logic       busy, done, timeout, ADC_CONVST, ADC_RD, ADC_PD;
  logic [7:0] result;

  int  nchk = 0;
  int  nerr = 0;
  logic eoc_en = 1'b0;
  int  conv_no = 0;
  int  skip_no = 0;

  adc_readout_ctrl dut (
    .clk_10MHz(clk), .reset(reset), .locked(locked), .start(start),
    .busy(busy), .done(done), .timeout(timeout), .result(result),
    .ADC_EOC(ADC_EOC), .Data(Data),
    .ADC_CONVST(ADC_CONVST), .ADC_RD(ADC_RD), .ADC_PD(ADC_PD)
  );

  always #50 clk = ~clk;

  // ADC model: EOC drops two cycles after CONVST release (five with the synchroniser)
  initial forever begin
    @(posedge ADC_CONVST);
    conv_no++;
    if (eoc_en && conv_no != skip_no) begin
      repeat (2) @(posedge clk);
      #1 ADC_EOC = 1'b0;
      repeat (6) @(posedge clk);
      #1 ADC_EOC = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ndone, nto;
    reset = 1'b1; locked = 1'b1; start = 1'b0; ADC_EOC = 1'b1; Data = 8'h00;
    repeat (3) tick();
    chk("rst_convst", ADC_CONVST, 1);
    chk("rst_rd", ADC_RD, 1);
    chk("rst_pd", ADC_PD, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_result", result, 8'h00);
    reset = 1'b0;
    repeat (2) tick();
    eoc_en = 1'b1;
`ifdef ADC_AVG_EN
    // four samples 1,2,3,5 -> sum 11 -> result 2
    begin
      logic [7:0] smp [4];
      int k;
      smp[0] = 8'h01; smp[1] = 8'h02; smp[2] = 8'h03; smp[3] = 8'h05;
      conv_no = 0; skip_no = 0; ndone = 0; nto = 0; k = 0;
      Data = smp[0];
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 80; i++) begin
        if (!ADC_RD && k < 4) begin Data = smp[k]; end
        if (!ADC_RD && i > 0) begin end
        tick();
        if (done) ndone++;
        if (timeout) nto++;
        chk("avg_strobe_excl", ADC_CONVST | ADC_RD, 1);
        if (ADC_RD && k < 4 && conv_no > k && i > 3 && !busy) begin end
        if (!ADC_RD) k = conv_no;
      end
      chk("avg_ndone", ndone, 1);
      chk("avg_nto", nto, 0);
      chk("avg_result", result, 8'h02);
      // timeout on the third conversion aborts the set
      conv_no = 0; skip_no = 3; ndone = 0; nto = 0;
      Data = 8'hF0;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 160; i++) begin
        tick();
        if (done) ndone++;
        if (timeout) nto++;
      end
      chk("avgto_ndone", ndone, 0);
      chk("avgto_nto", nto, 1);
      chk("avgto_result", result, 8'h02);
      chk("avgto_busy", busy, 0);
    end
`else
    // basic read: accept edge is index 0, done at index 11
    Data = 8'hA5;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("basic_convst_%0d", i), ADC_CONVST, (i < 2) ? 0 : 1);
      chk($sformatf("basic_rd_%0d", i), ADC_RD, (i >= 7 && i < 10) ? 0 : 1);
      chk($sformatf("basic_done_%0d", i), done, (i == 11) ? 1 : 0);
      chk($sformatf("basic_busy_%0d", i), busy, (i < 15) ? 1 : 0);
      if (i == 11) chk("basic_result", result, 8'hA5);
      tick();
    end
    // timeout: EOC never arrives, strobe 64 cycles after CONVST release
    eoc_en = 1'b0; Data = 8'h5A;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      chk($sformatf("to_pulse_%0d", i), timeout, (i == 66) ? 1 : 0);
      chk($sformatf("to_nodone_%0d", i), done, 0);
    end
    chk("to_result", result, 8'hA5);
    chk("to_idle", busy, 0);
    // lock loss in READ
    eoc_en = 1'b1; Data = 8'h33;
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    chk("ll_in_read", ADC_RD, 0);
    locked = 1'b0;
    tick();
    chk("ll_rd", ADC_RD, 1);
    chk("ll_convst", ADC_CONVST, 1);
    chk("ll_pd", ADC_PD, 1);
    chk("ll_busy", busy, 0);
    chk("ll_done", done, 0);
    repeat (2) begin
      tick();
      chk("ll_done_later", done, 0);
    end
    chk("ll_result", result, 8'hA5);
    locked = 1'b1; start = 1'b1;
    tick();
    chk("relock_pd", ADC_PD, 0);
    chk("relock_not_acc", busy, 0);
    tick();
    chk("relock_acc", busy, 1);
    chk("relock_convst", ADC_CONVST, 0);
    start = 1'b0;
    repeat (16) tick();
    chk("relock_result", result, 8'h33);
    chk("relock_idle", busy, 0);
    // asynchronous reset in the middle of CONV
    eoc_en = 1'b0; Data = 8'h77;
    start = 1'b1; tick(); start = 1'b0;
    chk("ar_convst_low", ADC_CONVST, 0);
    #20 reset = 1'b1;
    #1;
    chk("ar_convst", ADC_CONVST, 1);
    chk("ar_result", result, 8'h00);
    chk("ar_busy", busy, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    eoc_en = 1'b1;
    // back-to-back with start held: done strobes 16 cycles apart
    Data = 8'h10;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk($sformatf("b2b_done_%0d", i), done, (i == 11 || i == 27) ? 1 : 0);
      chk($sformatf("b2b_excl_%0d", i), ADC_CONVST | ADC_RD, 1);
      if (i == 11) begin
        chk("b2b_result1", result, 8'h10);
        Data = 8'h20;
      end
      if (i == 27) chk("b2b_result2", result, 8'h20);
    end
    start = 1'b0;
    repeat (6) tick();
    chk("b2b_idle", busy, 0);
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/adc_readout_ctrl.md
Name: adc_readout_ctrl

Overview:
- Converts one request from the RRAM sequencing FSM into a full conversion/read cycle on the external 8-bit parallel ADC.
- Drives ADC_CONVST, ADC_RD and ADC_PD, waits for ADC_EOC, and latches Data.
- Returns the result to the FSM with a one-cycle done strobe.
- Sits between the sequencing FSM and the ADC pins. Runs on clk_10MHz (100 ns per cycle).

Parameters:
- CONVST_CYC, 2, cycles ADC_CONVST is held low (>=1).
- RD_CYC, 3, cycles ADC_RD is held low before Data is sampled (>=1).
- EOC_TIMEOUT, 64, maximum cycles to wait for ADC_EOC low before aborting.
- RECOV_CYC, 4, idle cycles after ADC_RD release before the next conversion may start (>=1).

Ports:
- clk_10MHz input 1: system clock.
- reset input 1: asynchronous, active-high reset.
- locked input 1: clock-manager lock; operation only permitted while high.
- start input 1: conversion request from the FSM; sampled only in IDLE.
- busy output 1: high from the cycle after start is accepted until return to IDLE.
- done output 1: one-cycle strobe, result valid.
- timeout output 1: one-cycle strobe, EOC not seen within EOC_TIMEOUT.
- result output 8: last captured sample; held until the next done.
- ADC_EOC input 1: end-of-conversion from the ADC, active-low. Must pass through a 2-flop synchroniser before use.
- Data input 8: ADC parallel data bus.
- ADC_CONVST output 1: conversion start, active-low.
- ADC_RD output 1: read strobe, active-low.
- ADC_PD output 1: power-down, active-high.

Behaviour:
- Reset values: ADC_CONVST=1, ADC_RD=1, ADC_PD=0, busy=0, done=0, timeout=0, result=8'h00, state=IDLE, counters=0.
- All outputs are registered.
- IDLE:
  - If start=1 and locked=1, go to CONV and load the counter with CONVST_CYC.
  - start is ignored while locked=0; no queuing.
- CONV: ADC_CONVST=0 for exactly CONVST_CYC cycles, then ADC_CONVST=1 and go to WAIT_EOC. Load the counter with EOC_TIMEOUT.
- WAIT_EOC:
  - Synchronised EOC=0: go to READ and load the counter with RD_CYC.
  - Counter reaches 0 with EOC still high: pulse timeout for 1 cycle, leave result unchanged, go to RECOV.
- READ:
  - ADC_RD=0 for RD_CYC cycles.
  - On the last low cycle, register Data into an internal capture register.
  - Next cycle: ADC_RD=1, go to DONE.
- DONE: for one cycle, done=1 and result is updated to the capture; then go to RECOV with the counter loaded with RECOV_CYC.
- RECOV: ADC_RD=1 and ADC_CONVST=1 for RECOV_CYC cycles, then IDLE. start is not accepted here.
- busy=1 in every state except IDLE.
- done and timeout are never high together.
- Nominal latency, start to done (defaults, EOC 5 cycles after CONVST release including synchroniser): 1+2+5+3+1 = 12 cycles. Turnaround start-to-start: latency + RECOV_CYC.
- locked falls in any non-IDLE state:
  - Next cycle: ADC_CONVST=1, ADC_RD=1, state=IDLE.
  - No done, no timeout, result unchanged.
- ADC_PD:
  - Asserted (1) whenever locked=0.
  - Deasserted the first cycle locked=1.
  - No conversion starts in the same cycle PD deasserts; start is accepted from the following cycle.
- start held high continuously: one conversion per IDLE visit (back-to-back with RECOV gap).
- Reset mid-operation: immediately returns all outputs to reset values. An active ADC strobe is released asynchronously.
- ADC_CONVST and ADC_RD are never low simultaneously.

Optional Feature:
- Macro ADC_AVG_EN.
- When defined:
  - Each start performs 4 consecutive conversions (CONV..READ, with RECOV_CYC between them).
  - The 4 samples accumulate in a 10-bit adder; result = sum[9:2] (truncation).
  - done pulses once, after the 4th read.
  - A timeout on any conversion aborts the set: timeout pulses, result unchanged, accumulator cleared.
- When undefined: single conversion per start, no accumulator logic present.

Test Plan:
- Basic read:
  - Stimulus: locked=1, start pulse; model asserts EOC low 5 cycles after CONVST rises, Data=8'hA5.
  - Required: CONVST low 2 cycles, RD low 3 cycles, done 1 cycle at 12 cycles after start, result=8'hA5, busy low again after RECOV.
- Timeout:
  - Stimulus: EOC held high.
  - Required: timeout pulses EOC_TIMEOUT(64) cycles after CONVST release, done never asserts, result keeps its previous value (8'hA5).
- Lock loss:
  - Stimulus: drop locked while in READ.
  - Required: next cycle RD=1, CONVST=1, PD=1, busy=0, no done.
  - Stimulus: relock, then start.
  - Required: start accepted only from the second locked cycle.
- Async reset:
  - Stimulus: assert reset mid-CONV, between clock edges.
  - Required: CONVST returns to 1 without waiting for a clock edge, result=8'h00.
- Back-to-back:
  - Stimulus: start held high; Data 8'h10 then 8'h20.
  - Required: two done strobes separated by latency+RECOV_CYC cycles, results 8'h10 then 8'h20. CONVST and RD never low simultaneously (assertion).
- ADC_AVG_EN build:
  - Stimulus: samples 8'h01, 8'h02, 8'h03, 8'h05.
  - Required: single done, result=8'h02 (sum 11 >> 2). A timeout on the 3rd sample gives timeout only, no done.
